// File: rtl/adder_result_stage.sv
// Registered result stage behind the ripple adder: flags each sum, queues it in a
// 2-entry FIFO with valid/ready handshakes, and keeps a saturating overflow count.
module adder_result_stage #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [3:0]       out_flags,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] OVF_MAX = {CNT_W{1'b1}};

  logic [N-1:0] sum_mem   [2];
  logic [3:0]   flags_mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  logic         push;
  logic         pop;
  logic         flag_v;
  logic         flag_c;
  logic         flag_n;
  logic         flag_z;
  logic [3:0]   flags_in;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Carry is rebuilt from the operand and sum MSBs since the adder does not export it.
  assign flag_z   = (sum == '0);
  assign flag_n   = sum[N-1];
  assign flag_c   = (a[N-1] & b[N-1]) | ((a[N-1] | b[N-1]) & ~sum[N-1]);
  assign flag_v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
  assign flags_in = {flag_v, flag_c, flag_n, flag_z};

  always_ff @(posedge clk) begin
    if (push) begin
      sum_mem[wr_ptr]   <= sum;
      flags_mem[wr_ptr] <= flags_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign out_sum   = out_valid ? sum_mem[rd_ptr]   : '0;
  assign out_flags = out_valid ? flags_mem[rd_ptr] : 4'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (push && flag_v && (ovf_count != OVF_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage at N=8, CNT_W=2: expected entries are queued
// on accept and compared against the head every cycle, directed checks cover the corners.
module tb_adder_result_stage;

  localparam int N     = 8;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [N-1:0] sum;
    logic [3:0]   flags;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [N-1:0]     sum;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic [3:0]       out_flags;
  logic             ovf_clr;
  logic [CNT_W-1:0] ovf_count;

  int     n_vec  = 0;
  int     n_miss = 0;
  bit     mon_en = 1'b0;
  entry_t exp_q[$];
  int     exp_ovf = 0;

  adder_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference flags from a widened add, independent of the MSB-only formulas.
  function automatic logic [3:0] ref_flags(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] wide;
    int         sx;
    int         sy;
    int         ss;
    logic       v;
    wide = {1'b0, x} + {1'b0, y};
    sx   = $signed(x);
    sy   = $signed(y);
    ss   = sx + sy;
    v    = (ss > 127) || (ss < -128);
    return {v, wide[N], wide[N-1], (wide[N-1:0] == '0)};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        exp_q.delete();
        exp_ovf = 0;
      end else begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        chk("ovf_count", 32'(ovf_count), 32'(exp_ovf));
        if (exp_q.size() != 0) begin
          chk("head_sum", 32'(out_sum), 32'(exp_q[0].sum));
          chk("head_flags", 32'(out_flags), 32'(exp_q[0].flags));
          if (out_ready) void'(exp_q.pop_front());
        end else begin
          chk("empty_sum", 32'(out_sum), 32'd0);
          chk("empty_flags", 32'(out_flags), 32'd0);
        end
        if (in_valid && in_ready) begin
          entry_t e;
          e.sum   = a + b;
          e.flags = ref_flags(a, b);
          exp_q.push_back(e);
          if (ovf_clr) exp_ovf = 0;
          else if (e.flags[3] && exp_ovf != 3) exp_ovf++;
        end else if (ovf_clr) begin
          exp_ovf = 0;
        end
      end
    end
  end

  task automatic push(input logic [N-1:0] x, input logic [N-1:0] y);
    bit acc;
    int budget;
    a        = x;
    b        = y;
    sum      = x + y;
    in_valid = 1'b1;
    budget   = 0;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 20);
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    a         = '0;
    b         = '0;
    sum       = '0;
    idle(2);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_ovf", 32'(ovf_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // first entry: signed overflow into the sign bit
    push(8'h7F, 8'h01);
    @(negedge clk);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_sum", 32'(out_sum), 32'h80);
    chk("t1_flags", 32'(out_flags), 32'hA);
    chk("t1_ovf", 32'(ovf_count), 32'd1);
    @(posedge clk);
    #1;

    push(8'hFF, 8'h01);
    @(negedge clk);
    chk("t2_flags_cz", 32'(out_flags), 32'h5);
    @(posedge clk);
    #1;
    push(8'h80, 8'h80);
    @(negedge clk);
    chk("t2_flags_vcz", 32'(out_flags), 32'hD);
    @(posedge clk);
    #1;
    idle(2);

    // fill while stalled, third push waits upstream until the consumer drains
    out_ready = 1'b0;
    push(8'h11, 8'h00);
    push(8'h22, 8'h00);
    fork
      push(8'h33, 8'h00);
      begin
        idle(3);
        chk("t3_full", {31'd0, in_ready}, 32'd0);
        chk("t3_head_held", 32'(out_sum), 32'h11);
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // steady push and pop at occupancy 1
    for (int i = 0; i < 6; i++) push(8'(8'h40 + i), 8'h01);
    chk("t4_occ", 32'(exp_q.size()), 32'd1);
    idle(3);

    // saturation, then clear colliding with an overflowing accept
    for (int i = 0; i < 5; i++) push(8'h7F, 8'(i + 1));
    @(negedge clk);
    chk("t5_sat", 32'(ovf_count), 32'd3);
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    push(8'h40, 8'h40);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr", 32'(ovf_count), 32'd0);
    @(posedge clk);
    #1;
    idle(3);

    // reset with two stalled entries queued
    out_ready = 1'b0;
    push(8'h60, 8'h60);
    push(8'hA0, 8'hA0);
    @(negedge clk);
    chk("t6_pre_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_flags", 32'(out_flags), 32'd0);
    chk("t6_ovf", 32'(ovf_count), 32'd0);
    out_ready = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
